alu_seq: RTL

Sequential, handshaked ALU execution unit for the IDIOT datapath: the responder side of the X/Y/ALUop operand interface. It accepts one 16-bit operation per request and returns a registered 16-bit result with a valid/ready handshake. Shifts are performed iteratively, one bit per cycle, instead of with a barrel shifter. It sits between the decode/operand-fetch stage, which issues requests, and writeback, which consumes responses.

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_shifter.sv | 39 +++
 rtl/alu_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: op encodings, FSM states, word width.
package alu_seq_pkg;

    localparam int WORD = 16;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_AND = 3'd1,
        ALU_OR  = 3'd2,
        ALU_XOR = 3'd3,
        ALU_SUB = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_shift(input alu_op_e op);
        return (op == ALU_SHL) || (op == ALU_SHR);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative one-bit-per-cycle shifter; holds the accumulator and remaining count.
module alu_shifter #(
    parameter int WIDTH = 16,
    parameter int SHCNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_left,
    input  logic [WIDTH-1:0] i_x,
    input  logic [SHCNT-1:0] i_amt,
    output logic [WIDTH-1:0] o_acc,
    output logic             o_done
);

    logic [WIDTH-1:0] r_acc;
    logic [SHCNT-1:0] r_cnt;
    logic             r_left;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_left <= 1'b0;
        end else if (i_load) begin
            r_acc  <= i_x;
            r_cnt  <= i_amt;
            r_left <= i_left;
        end else if (i_step && (r_cnt != '0)) begin
            r_acc <= r_left ? (r_acc << 1) : (r_acc >> 1);
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_acc  = r_acc;
    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU execution unit; logic ops finish in one cycle, shifts iterate.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int SHCNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_x,
    input  logic [WIDTH-1:0] req_y,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_z
);

    state_e           r_state;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic [WIDTH-1:0] r_resp_z;

    alu_op_e          w_op;
    logic             w_accept;
    logic             w_shift;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_acc;
    logic             w_sh_done;

    assign w_op     = alu_op_e'(req_op);
    assign w_accept = req_valid && r_req_ready;
    assign w_shift  = is_shift(w_op);

    always_comb begin
        w_result = '0;
        unique case (w_op)
            ALU_ADD: w_result = req_x + req_y;
            ALU_AND: w_result = req_x & req_y;
            ALU_OR:  w_result = req_x | req_y;
            ALU_XOR: w_result = req_x ^ req_y;
            ALU_SUB: w_result = req_x - req_y;
            ALU_SLT: w_result = {{(WIDTH-1){1'b0}},
                                 ($signed(req_x) < $signed(req_y))};
            ALU_SHL: w_result = '0;
            ALU_SHR: w_result = '0;
        endcase
    end

    alu_shifter #(
        .WIDTH(WIDTH),
        .SHCNT(SHCNT)
    ) u_shifter (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_accept && w_shift),
        .i_step (r_state == ST_SHIFT),
        .i_left (w_op == ALU_SHL),
        .i_x    (req_x),
        .i_amt  (req_y[SHCNT-1:0]),
        .o_acc  (w_acc),
        .o_done (w_sh_done)
    );

    // req_ready stays low through the reset cycle and rises one edge later
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_z     <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_req_ready <= !w_accept;
                    if (w_accept) begin
                        if (w_shift) begin
                            r_state <= ST_SHIFT;
                        end else begin
                            r_state      <= ST_DONE;
                            r_resp_valid <= 1'b1;
                            r_resp_z     <= w_result;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_sh_done) begin
                        r_state      <= ST_DONE;
                        r_resp_valid <= 1'b1;
                        r_resp_z     <= w_acc;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_z     = r_resp_z;

endmodule
